// File: rtl/fb_arb_pkg.sv
// Shared types and default geometry for the thermal framebuffer port arbiter.
// Optional statistics counters are enabled by defining FB_ARB_STATS_EN.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam int DEF_FB_WIDTH   = 160;
    localparam int DEF_FB_HEIGHT  = 120;
    localparam int DEF_PIX_W      = 8;
    localparam int DEF_RD_LATENCY = 1;

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return tracker: delays {valid,col,last} by the RAM read latency so the
// line-buffer strobe lines up with the data coming back from the framebuffer.
module fb_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int COL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [COL_W-1:0] src_col,
    input  logic             src_last,
    output logic             dst_valid,
    output logic [COL_W-1:0] dst_col,
    output logic             dst_last
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] l;
    logic [COL_W-1:0] c [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            l <= '0;
            for (int i = 0; i < DEPTH; i++) c[i] <= '0;
        end else begin
            v[0] <= src_valid;
            c[0] <= src_col;
            l[0] <= src_last;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                c[i] <= c[i-1];
                l[i] <= l[i-1];
            end
        end
    end

    assign dst_valid = v[DEPTH-1];
    assign dst_col   = c[DEPTH-1];
    assign dst_last  = l[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display line prefetch has priority over the
// camera writer. Define FB_ARB_STATS_EN to add stall/overrun counters.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int  FB_WIDTH   = DEF_FB_WIDTH,
    parameter int  FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int  PIX_W      = DEF_PIX_W,
    parameter int  RD_LATENCY = DEF_RD_LATENCY,
    localparam int ADDR_W     = $clog2(FB_WIDTH * FB_HEIGHT),
    localparam int Y_W        = $clog2(FB_HEIGHT),
    localparam int COL_W      = $clog2(FB_WIDTH)
) (
    input  logic              i_clk_pixel,
    input  logic              i_rst,
    input  logic              i_line_req,
    input  logic [Y_W-1:0]    i_line_y,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [PIX_W-1:0]  o_mem_wdata,
    input  logic [PIX_W-1:0]  i_mem_rdata,
    output logic              o_lb_we,
    output logic              o_lb_bank,
    output logic [COL_W-1:0]  o_lb_addr,
    output logic [PIX_W-1:0]  o_lb_data,
    output logic              o_line_done,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]       o_stall_cnt,
    output logic [7:0]        o_overrun_cnt,
`endif
    output logic              o_overrun
);

    localparam int DRN_W = $clog2(RD_LATENCY + 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [COL_W-1:0]  col;
    logic [DRN_W-1:0]  drn;
    logic              fetching;
    logic              last_col;
    logic              accept;
    logic              drop;
    logic              wr_go;
    logic              pv;
    logic              pl;
    logic [COL_W-1:0]  pc;

    assign fetching = (state == FETCH);
    assign last_col = (col == COL_W'(FB_WIDTH - 1));
    assign accept   = (state == IDLE) && i_line_req
                    && ({1'b0, i_line_y} < (Y_W + 1)'(FB_HEIGHT));
    assign drop     = (state != IDLE) && i_line_req;

    // A line request in the same cycle steals the port from the writer.
    assign o_wr_ready = (state == IDLE) && !i_line_req && !i_rst;
    assign wr_go      = i_wr_valid && o_wr_ready;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (fetching) begin
            o_mem_addr = base + ADDR_W'(col);
        end else if (wr_go) begin
            o_mem_addr  = i_wr_addr;
            o_mem_we    = 1'b1;
            o_mem_wdata = i_wr_data;
        end
    end

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            state     <= IDLE;
            base      <= '0;
            col       <= '0;
            drn       <= '0;
            o_lb_bank <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= drop;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= FETCH;
                        base      <= ADDR_W'(i_line_y) * ADDR_W'(FB_WIDTH);
                        col       <= '0;
                        o_lb_bank <= ~o_lb_bank;
                    end
                end
                FETCH: begin
                    if (last_col) begin
                        state <= DRAIN;
                        drn   <= '0;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                DRAIN: begin
                    if (drn == DRN_W'(RD_LATENCY - 1)) state <= IDLE;
                    else drn <= drn + DRN_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    fb_rd_pipe #(
        .DEPTH (RD_LATENCY),
        .COL_W (COL_W)
    ) u_rd_pipe (
        .clk       (i_clk_pixel),
        .rst       (i_rst),
        .src_valid (fetching),
        .src_col   (col),
        .src_last  (last_col),
        .dst_valid (pv),
        .dst_col   (pc),
        .dst_last  (pl)
    );

    assign o_lb_we     = pv;
    assign o_lb_addr   = pv ? pc : '0;
    assign o_lb_data   = pv ? i_mem_rdata : '0;
    assign o_line_done = pv && pl;

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            o_stall_cnt   <= '0;
            o_overrun_cnt <= '0;
        end else begin
            if (i_wr_valid && !o_wr_ready && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + 16'd1;
            if (drop && o_overrun_cnt != '1)
                o_overrun_cnt <= o_overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
